// File: rtl/uart_autobaud.sv
// Auto-baud controller: times a 0x55 sync character on rxd and derives the shared UART prescale.
// Define UART_AUTOBAUD_CHECK_EN to add per-bit interval plausibility checks during measurement.
module uart_autobaud #(
    parameter int CNT_WIDTH    = 24,
    parameter int IDLE_CYCLES  = 256,
    parameter int MIN_PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    input  logic        arm,
    input  logic [15:0] default_prescale,
    output logic [15:0] prescale,
    output logic        locked,
    output logic        busy,
    output logic        detect_error
);

    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam int PW     = (CNT_WIDTH + 1 > 17) ? CNT_WIDTH + 1 : 17;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IDLE,
        S_WAIT_START,
        S_MEASURE,
        S_COMPUTE,
        S_CHECK_STOP,
        S_ERROR,
        S_LOCKED
    } state_t;

    state_t state, state_next;

    logic                 rxd_meta, rxd_sync, rxd_sync_d;
    logic [IDLE_W-1:0]    idle_cnt;
    logic [CNT_WIDTH-1:0] period_cnt;
    logic [CNT_WIDTH-1:0] t_cap;
    logic [CNT_WIDTH-1:0] stop_cnt;
    logic [3:0]           edge_cnt;
    logic [15:0]          measured_prescale;
    logic                 edge_det, fall_det, rise_det;
    logic                 idle_done, period_max, p_ok, interval_err;
    logic [CNT_WIDTH:0]   t_round;
    logic [PW-1:0]        p_full;

    assign edge_det   = rxd_sync ^ rxd_sync_d;
    assign fall_det   = rxd_sync_d & ~rxd_sync;
    assign rise_det   = ~rxd_sync_d & rxd_sync;
    assign idle_done  = rxd_sync && (idle_cnt == IDLE_W'(IDLE_CYCLES - 1));
    assign period_max = &period_cnt;

    // Bit time is 8*prescale and T spans 8 bit times, so prescale = T/64, rounded to nearest.
    assign t_round = {1'b0, t_cap} + (CNT_WIDTH + 1)'(32);
    assign p_full  = PW'(t_round >> 6);
    assign p_ok    = (p_full <= PW'(17'h0FFFF)) && (p_full >= PW'(MIN_PRESCALE));

`ifdef UART_AUTOBAUD_CHECK_EN
    logic [CNT_WIDTH-1:0] ivl_cnt;
    logic [CNT_WIDTH-1:0] i0;
    logic [CNT_WIDTH:0]   ivl, i0_half, i0_double;

    assign ivl       = {1'b0, ivl_cnt} + (CNT_WIDTH + 1)'(1);
    assign i0_half   = {2'b00, i0[CNT_WIDTH-1:1]};
    assign i0_double = {i0, 1'b0};

    // Overlong intervals abort as soon as they exceed 2*I0; short ones are judged at their edge.
    assign interval_err = (edge_cnt != 4'd0) &&
                          ((ivl > i0_double) || (edge_det && (ivl < i0_half)));

    always_ff @(posedge clk) begin
        if (rst) begin
            ivl_cnt <= '0;
            i0      <= '0;
        end else if (state == S_WAIT_START) begin
            ivl_cnt <= '0;
        end else if (state == S_MEASURE) begin
            ivl_cnt <= edge_det ? '0 : ivl_cnt + CNT_WIDTH'(1);
            if (edge_det && (edge_cnt == 4'd0))
                i0 <= ivl[CNT_WIDTH-1:0];
        end
    end
`else
    assign interval_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:       state_next = S_IDLE;
            S_WAIT_IDLE:  if (idle_done) state_next = S_WAIT_START;
            S_WAIT_START: if (fall_det) state_next = S_MEASURE;
            S_MEASURE: begin
                if (edge_cnt == 4'd8)
                    state_next = S_COMPUTE;
                else if (interval_err || period_max)
                    state_next = S_ERROR;
            end
            S_COMPUTE:    state_next = p_ok ? S_CHECK_STOP : S_ERROR;
            S_CHECK_STOP: begin
                if (rise_det)
                    state_next = S_LOCKED;
                else if (stop_cnt == '0)
                    state_next = S_ERROR;
            end
            S_ERROR:      state_next = S_WAIT_IDLE;
            S_LOCKED:     state_next = S_LOCKED;
            default:      state_next = S_IDLE;
        endcase
        // A new arm request always restarts detection, even over a completing measurement.
        if (arm)
            state_next = S_WAIT_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta          <= 1'b1;
            rxd_sync          <= 1'b1;
            rxd_sync_d        <= 1'b1;
            idle_cnt          <= '0;
            period_cnt        <= '0;
            edge_cnt          <= '0;
            t_cap             <= '0;
            stop_cnt          <= '0;
            measured_prescale <= '0;
        end else begin
            rxd_meta   <= rxd;
            rxd_sync   <= rxd_meta;
            rxd_sync_d <= rxd_sync;

            if ((state == S_WAIT_IDLE) && rxd_sync && !arm)
                idle_cnt <= idle_cnt + IDLE_W'(1);
            else
                idle_cnt <= '0;

            case (state)
                S_WAIT_START: begin
                    period_cnt <= '0;
                    edge_cnt   <= '0;
                end
                S_MEASURE: begin
                    period_cnt <= period_cnt + CNT_WIDTH'(1);
                    if (edge_det && (edge_cnt != 4'd8))
                        edge_cnt <= edge_cnt + 4'd1;
                    if (edge_cnt == 4'd8)
                        t_cap <= period_cnt;
                end
                S_COMPUTE: begin
                    if (p_ok) begin
                        measured_prescale <= p_full[15:0];
                        stop_cnt          <= t_cap >> 2;
                    end
                end
                S_CHECK_STOP: begin
                    if (stop_cnt != '0)
                        stop_cnt <= stop_cnt - CNT_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    assign locked       = (state == S_LOCKED);
    assign busy         = (state != S_IDLE) && (state != S_LOCKED);
    assign detect_error = (state == S_ERROR);
    assign prescale     = locked ? measured_prescale : default_prescale;

endmodule

// File: tb/tb_uart_autobaud.sv
// Directed bench for uart_autobaud: a default instance plus a 12-bit counter instance for timeouts.
// Honours UART_AUTOBAUD_CHECK_EN for the stretched-bit and timeout scenarios.
module tb_uart_autobaud;

    logic        clk;
    logic        rst;
    logic        rxd;
    logic        arm;
    logic [15:0] default_prescale;
    logic [15:0] prescale, prescale_s;
    logic        locked, busy, detect_error;
    logic        locked_s, busy_s, detect_error_s;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    uart_autobaud dut (
        .clk              (clk),
        .rst              (rst),
        .rxd              (rxd),
        .arm              (arm),
        .default_prescale (default_prescale),
        .prescale         (prescale),
        .locked           (locked),
        .busy             (busy),
        .detect_error     (detect_error)
    );

    uart_autobaud #(.CNT_WIDTH(12)) dut_small (
        .clk              (clk),
        .rst              (rst),
        .rxd              (rxd),
        .arm              (arm),
        .default_prescale (default_prescale),
        .prescale         (prescale_s),
        .locked           (locked_s),
        .busy             (busy_s),
        .detect_error     (detect_error_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus tasks start and end just after a falling edge; step() samples #1 after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_line(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic drive_bits(input logic [7:0] data, input int bclk,
                              input int stretch_bit, input int stretch_clks);
        rxd = 1'b0;
        repeat (bclk) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            repeat ((i == stretch_bit) ? stretch_clks : bclk) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rxd = 1'b1;
        arm = 1'b0;
        default_prescale = 16'd7;
        repeat (3) @(negedge clk);
        step();
        tests_run++;
        if ({locked, busy, detect_error} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got %b, expected 000", {locked, busy, detect_error});
        end
        tests_run++;
        if (prescale !== 16'd7) begin
            tests_failed++;
            $display("[TB] FAIL reset_prescale: got %0d, expected 7", prescale);
        end
        tests_run++;
        if ({locked_s, busy_s, detect_error_s} !== 3'b000 || prescale_s !== 16'd7) begin
            tests_failed++;
            $display("[TB] FAIL reset_small: got flags %b prescale %0d, expected 000 / 7",
                     {locked_s, busy_s, detect_error_s}, prescale_s);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_lock_24();
        default_prescale = 16'd7;
        pulse_arm();
        tests_run++;
        if (busy !== 1'b1 || locked !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL lock24_armed: got busy %b locked %b, expected 1 0", busy, locked);
        end
        idle_line(300);
        drive_bits(8'h55, 24, -1, 0);
        step();
        tests_run++;
        if (busy !== 1'b1 || prescale !== 16'd7) begin
            tests_failed++;
            $display("[TB] FAIL lock24_measuring: got busy %b prescale %0d, expected 1 7", busy, prescale);
        end
        @(negedge clk);
        rxd = 1'b1;
        step();
        step();
        tests_run++;
        if (locked !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL lock24_early: got locked %b, expected 0", locked);
        end
        step();
        tests_run++;
        if (locked !== 1'b1 || prescale !== 16'd3 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL lock24_locked: got locked %b prescale %0d busy %b, expected 1 3 0",
                     locked, prescale, busy);
        end
        @(negedge clk);
        // A further frame while locked must not disturb the held value.
        drive_bits(8'h55, 24, -1, 0);
        idle_line(50);
        step();
        tests_run++;
        if (locked !== 1'b1 || prescale !== 16'd3) begin
            tests_failed++;
            $display("[TB] FAIL lock24_hold: got locked %b prescale %0d, expected 1 3", locked, prescale);
        end
        @(negedge clk);
    endtask

    task automatic test_lock_868();
        default_prescale = 16'd50;
        pulse_arm();
        tests_run++;
        if (locked !== 1'b0 || prescale !== 16'd50) begin
            tests_failed++;
            $display("[TB] FAIL rearm_revert: got locked %b prescale %0d, expected 0 50", locked, prescale);
        end
        idle_line(300);
        drive_bits(8'h55, 868, -1, 0);
        step();
        tests_run++;
        if (locked !== 1'b0 || prescale !== 16'd50) begin
            tests_failed++;
            $display("[TB] FAIL lock868_default: got locked %b prescale %0d, expected 0 50", locked, prescale);
        end
        @(negedge clk);
        rxd = 1'b1;
        step();
        step();
        step();
        tests_run++;
        if (locked !== 1'b1 || prescale !== 16'd109) begin
            tests_failed++;
            $display("[TB] FAIL lock868_locked: got locked %b prescale %0d, expected 1 109", locked, prescale);
        end
        @(negedge clk);
    endtask

    task automatic test_too_fast();
        int err_n;
        int lock_n;
        err_n  = 0;
        lock_n = 0;
        default_prescale = 16'd50;
        pulse_arm();
        idle_line(300);
        drive_bits(8'h55, 2, -1, 0);
        rxd = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (detect_error === 1'b1) err_n++;
            if (locked === 1'b1) lock_n++;
        end
        tests_run++;
        if (err_n !== 1) begin
            tests_failed++;
            $display("[TB] FAIL fast_error_pulse: got %0d error cycles, expected 1", err_n);
        end
        tests_run++;
        if (lock_n !== 0 || prescale !== 16'd50) begin
            tests_failed++;
            $display("[TB] FAIL fast_unlocked: got %0d locked cycles prescale %0d, expected 0 50",
                     lock_n, prescale);
        end
        @(negedge clk);
        // Auto-retry: no arm, the next good frame must lock.
        idle_line(300);
        drive_bits(8'h55, 24, -1, 0);
        rxd = 1'b1;
        step();
        step();
        step();
        tests_run++;
        if (locked !== 1'b1 || prescale !== 16'd3) begin
            tests_failed++;
            $display("[TB] FAIL fast_retry_lock: got locked %b prescale %0d, expected 1 3", locked, prescale);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int start_cyc;
        int err_cyc;
        int err_n;
        err_n   = 0;
        err_cyc = 0;
        pulse_arm();
        idle_line(300);
        start_cyc = cyc;
        drive_bits(8'h41, 24, -1, 0);
        rxd = 1'b1;
        for (int i = 0; i < 4300; i++) begin
            step();
            if (detect_error_s === 1'b1) begin
                err_n++;
                err_cyc = cyc;
            end
        end
        tests_run++;
        if (err_n !== 1) begin
            tests_failed++;
            $display("[TB] FAIL timeout_pulse: got %0d error cycles, expected 1", err_n);
        end
`ifdef UART_AUTOBAUD_CHECK_EN
        tests_run++;
        if (!(err_cyc - start_cyc < 4099)) begin
            tests_failed++;
            $display("[TB] FAIL timeout_time: got %0d cycles, expected below 4099", err_cyc - start_cyc);
        end
`else
        tests_run++;
        if (err_cyc - start_cyc !== 4099) begin
            tests_failed++;
            $display("[TB] FAIL timeout_time: got %0d cycles, expected 4099", err_cyc - start_cyc);
        end
`endif
        tests_run++;
        if (locked_s !== 1'b0 || busy_s !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL timeout_retry: got locked %b busy %b, expected 0 1", locked_s, busy_s);
        end
        @(negedge clk);
    endtask

    task automatic test_stretched();
        int start_cyc;
        int err_cyc;
        int err_n;
        err_n   = 0;
        err_cyc = 0;
        pulse_arm();
        idle_line(300);
        start_cyc = cyc;
        fork
            drive_bits(8'h55, 24, 3, 72);
            begin
                for (int i = 0; i < 264; i++) begin
                    step();
                    if (detect_error === 1'b1) begin
                        err_n++;
                        err_cyc = cyc;
                    end
                end
            end
        join
`ifdef UART_AUTOBAUD_CHECK_EN
        tests_run++;
        if (err_n !== 1 || err_cyc - start_cyc !== 148) begin
            tests_failed++;
            $display("[TB] FAIL stretch_error: got %0d pulses at %0d, expected 1 at 148",
                     err_n, err_cyc - start_cyc);
        end
        @(negedge clk);
        idle_line(10);
`else
        tests_run++;
        if (err_n !== 0) begin
            tests_failed++;
            $display("[TB] FAIL stretch_noerror: got %0d error cycles, expected 0", err_n);
        end
        @(negedge clk);
        rxd = 1'b1;
        step();
        step();
        step();
        tests_run++;
        if (locked !== 1'b1 || prescale !== 16'd4) begin
            tests_failed++;
            $display("[TB] FAIL stretch_lock: got locked %b prescale %0d, expected 1 4", locked, prescale);
        end
        @(negedge clk);
`endif
    endtask

    task automatic test_reset_mid();
        default_prescale = 16'd21;
        pulse_arm();
        idle_line(300);
        rxd = 1'b0; repeat (24) @(negedge clk);
        rxd = 1'b1; repeat (24) @(negedge clk);
        rxd = 1'b0; repeat (24) @(negedge clk);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midreset_busy: got %b, expected 1", busy);
        end
        rst = 1'b1;
        step();
        tests_run++;
        if ({locked, busy, detect_error} !== 3'b000 || prescale !== 16'd21) begin
            tests_failed++;
            $display("[TB] FAIL midreset_clear: got flags %b prescale %0d, expected 000 21",
                     {locked, busy, detect_error}, prescale);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 3; i < 8; i++) begin
            rxd = ~rxd;
            repeat (24) @(negedge clk);
        end
        idle_line(30);
        tests_run++;
        if (busy !== 1'b0 || locked !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_idle: got busy %b locked %b, expected 0 0", busy, locked);
        end
    endtask

    task automatic test_arm_abort();
        int err_n;
        err_n = 0;
        pulse_arm();
        idle_line(300);
        rxd = 1'b0; repeat (24) @(negedge clk);
        rxd = 1'b1; repeat (24) @(negedge clk);
        rxd = 1'b0; repeat (24) @(negedge clk);
        pulse_arm();
        fork
            begin
                for (int i = 3; i < 8; i++) begin
                    rxd = ~rxd;
                    repeat (24) @(negedge clk);
                end
                rxd = 1'b1;
            end
            begin
                for (int i = 0; i < 120; i++) begin
                    step();
                    if (detect_error === 1'b1) err_n++;
                end
            end
        join
        tests_run++;
        if (err_n !== 0 || busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL abort_silent: got %0d error cycles busy %b, expected 0 1", err_n, busy);
        end
        @(negedge clk);
        idle_line(300);
        drive_bits(8'h55, 24, -1, 0);
        rxd = 1'b1;
        @(negedge clk);
        @(negedge clk);
        // Arm lands on the cycle the stop-bit rise is seen and must win over the lock.
        arm = 1'b1;
        step();
        tests_run++;
        if (locked !== 1'b0 || busy !== 1'b1 || prescale !== 16'd21 || detect_error !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL arm_wins: got locked %b busy %b prescale %0d err %b, expected 0 1 21 0",
                     locked, busy, prescale, detect_error);
        end
        @(negedge clk);
        arm = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rxd = 1'b1;
        arm = 1'b0;
        default_prescale = 16'd7;
        @(negedge clk);
        test_reset();
        test_lock_24();
        test_lock_868();
        test_too_fast();
        test_timeout();
        test_stretched();
        test_reset_mid();
        test_arm_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
